// File: rtl/hazard_stall_if.sv
// -----------------------------------------------------------------------------
// hazard_stall_if
//   Bundles the signals exchanged between the 5-stage MIPS pipeline and the
//   hazard/stall controller that sits beside the ID stage.
//
//   master : pipeline side. Drives the ID/EX/MEM status, receives the hold and
//            flush controls.
//   slave  : controller side. Receives the status, drives the controls.
//
//   Status (master -> slave)
//     id_rs, id_rt   ID source registers
//     id_uses_rt     ID instruction reads rt
//     ex_rd          EX destination register (rt for lw)
//     ex_mem_read    EX instruction is a load
//     branch_taken   EX branch resolved taken this cycle
//     mem_busy       data memory not ready; MEM must hold
//   Controls (slave -> master)
//     pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze,
//     stall_active
// -----------------------------------------------------------------------------
interface hazard_stall_if #(
    parameter int REG_W = 5
);
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic [REG_W-1:0] ex_rd;
    logic             ex_mem_read;
    logic             branch_taken;
    logic             mem_busy;

    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             pipe_freeze;
    logic             stall_active;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_rd, ex_mem_read, branch_taken, mem_busy,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, stall_active
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_rd, ex_mem_read, branch_taken, mem_busy,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, stall_active
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// -----------------------------------------------------------------------------
// hazard_stall_controller
//   Owns every pipeline hold and flush control of the 5-stage MIPS pipeline.
//   Detects load-use hazards in the same cycle they appear and inserts exactly
//   LOAD_LAT bubbles per hazard, flushes IF/ID on a taken branch, freezes the
//   back half of the pipe while data memory is busy, and never treats $0 as a
//   dependency.
//
//   Parameters
//     REG_W     register-address width
//     LOAD_LAT  load-use bubbles per hazard (1..15)
//     CNT_W     stall-counter width, must hold LOAD_LAT-1
//
//   Ports
//     clk        pipeline clock, rising edge
//     rst_n      asynchronous active-low reset
//     hz         hazard_stall_if.slave (status in, hold/flush controls out)
//
//   Optional feature, macro HAZARD_PERF_CNT_EN:
//     perf_clr      in   1   synchronous clear of both counters
//     perf_stalls   out  16  saturating count of stall_active cycles
//     perf_flushes  out  16  saturating count of branch flush cycles
//   Without the macro these ports and counters do not exist.
//
//   Outputs are combinational from the registered state and the current
//   inputs; only the FSM state and the stall counter are registered.
// -----------------------------------------------------------------------------
module hazard_stall_controller #(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_stall_if.slave       hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    input  logic                perf_clr,
    output logic [15:0]         perf_stalls,
    output logic [15:0]         perf_flushes
`endif
);

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } state_t;

    // With a single bubble the hazard is fully covered by the RUN-state stall
    // cycle, so the FSM never needs to leave RUN.
    localparam bit MULTI_CYCLE = (LOAD_LAT > 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;

    logic lu_hit;
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic pipe_freeze;
    logic stall_active;

    // $0 is hard-wired to zero, so a load targeting it creates no dependency.
    always_comb begin
        lu_hit = hz.ex_mem_read
               && (hz.ex_rd != '0)
               && ((hz.ex_rd == hz.id_rs)
                   || (hz.id_uses_rt && (hz.ex_rd == hz.id_rt)));
    end

    // Control outputs. Priority: reset > mem_busy > branch_taken > load-use > pass.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        stall_active = 1'b0;

        if (!rst_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (hz.mem_busy) begin
            // Whole pipe holds; no bubble so the frozen EX/MEM contents survive.
            // A stall already underway is still in progress, only paused.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            pipe_freeze  = 1'b1;
            stall_active = (state_q == LU_STALL);
        end else if (hz.branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if ((state_q == LU_STALL) || lu_hit) begin
            // In LU_STALL the load has already left EX, so lu_hit is no longer
            // visible; the stall is driven by the state alone.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            stall_active = 1'b1;
        end
    end

    assign hz.pc_write     = pc_write;
    assign hz.if_id_write  = if_id_write;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_bubble = id_ex_bubble;
    assign hz.pipe_freeze  = pipe_freeze;
    assign hz.stall_active = stall_active;

    // Stall sequencer. A memory wait freezes state and counter so each busy
    // cycle stretches the stall by exactly one cycle. A taken branch aborts
    // any stall because the stalled ID instruction is on the wrong path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else if (!hz.mem_busy) begin
            if (hz.branch_taken) begin
                state_q <= RUN;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    RUN: begin
                        if (lu_hit && MULTI_CYCLE) begin
                            state_q <= LU_STALL;
                            cnt_q   <= CNT_W'(LOAD_LAT - 1);
                        end
                    end
                    LU_STALL: begin
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= RUN;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q   <= cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] perf_stalls_q;
    logic [15:0] perf_stalls_d;
    logic [15:0] perf_flushes_q;
    logic [15:0] perf_flushes_d;

    // Counters saturate at all-ones; clear overrides any increment.
    always_comb begin
        perf_stalls_d  = perf_stalls_q;
        perf_flushes_d = perf_flushes_q;
        if (perf_clr) begin
            perf_stalls_d  = '0;
            perf_flushes_d = '0;
        end else if (!hz.mem_busy) begin
            if (stall_active && (perf_stalls_q != 16'hFFFF)) begin
                perf_stalls_d = perf_stalls_q + 16'd1;
            end
            if (if_id_flush && (perf_flushes_q != 16'hFFFF)) begin
                perf_flushes_d = perf_flushes_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stalls_q  <= '0;
            perf_flushes_q <= '0;
        end else begin
            perf_stalls_q  <= perf_stalls_d;
            perf_flushes_q <= perf_flushes_d;
        end
    end

    assign perf_stalls  = perf_stalls_q;
    assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
`timescale 1ns/1ps
module tb_hazard_stall_controller;

    // Output vector order: {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, stall_active}
    localparam logic [5:0] V_PASS  = 6'b110000;
    localparam logic [5:0] V_STALL = 6'b000101;
    localparam logic [5:0] V_RST   = 6'b000100;
    localparam logic [5:0] V_FRZLU = 6'b000011;
    localparam logic [5:0] V_FRZ   = 6'b000010;
    localparam logic [5:0] V_FLUSH = 6'b111100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs, rt, exrd;
    logic       uses_rt, mr, br, busy;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    hazard_stall_if #(.REG_W(5)) if1 ();
    hazard_stall_if #(.REG_W(5)) if3 ();

    assign if1.id_rs = rs;   assign if3.id_rs = rs;
    assign if1.id_rt = rt;   assign if3.id_rt = rt;
    assign if1.id_uses_rt = uses_rt;  assign if3.id_uses_rt = uses_rt;
    assign if1.ex_rd = exrd; assign if3.ex_rd = exrd;
    assign if1.ex_mem_read = mr;  assign if3.ex_mem_read = mr;
    assign if1.branch_taken = br; assign if3.branch_taken = br;
    assign if1.mem_busy = busy;   assign if3.mem_busy = busy;

    wire [5:0] o1 = {if1.pc_write, if1.if_id_write, if1.if_id_flush,
                     if1.id_ex_bubble, if1.pipe_freeze, if1.stall_active};
    wire [5:0] o3 = {if3.pc_write, if3.if_id_write, if3.if_id_flush,
                     if3.id_ex_bubble, if3.pipe_freeze, if3.stall_active};

`ifdef HAZARD_PERF_CNT_EN
    logic        perf_clr;
    logic [15:0] ps1, pf1, ps3, pf3;

    hazard_stall_controller #(.REG_W(5), .LOAD_LAT(1), .CNT_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .hz(if1.slave),
        .perf_clr(perf_clr), .perf_stalls(ps1), .perf_flushes(pf1));
    hazard_stall_controller #(.REG_W(5), .LOAD_LAT(3), .CNT_W(4)) u3 (
        .clk(clk), .rst_n(rst_n), .hz(if3.slave),
        .perf_clr(perf_clr), .perf_stalls(ps3), .perf_flushes(pf3));
`else
    hazard_stall_controller #(.REG_W(5), .LOAD_LAT(1), .CNT_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .hz(if1.slave));
    hazard_stall_controller #(.REG_W(5), .LOAD_LAT(3), .CNT_W(4)) u3 (
        .clk(clk), .rst_n(rst_n), .hz(if3.slave));
`endif

    task automatic idle();
        rs = 5'd0; rt = 5'd0; exrd = 5'd0;
        uses_rt = 1'b0; mr = 1'b0; br = 1'b0; busy = 1'b0;
    endtask

    // Load in EX writing r5, ID reads r5 through rs.
    task automatic hazard();
        idle();
        mr = 1'b1; exrd = 5'd5; rs = 5'd5;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        #1;
        checks++; if (o1 !== V_RST) begin fails++; $display("FAIL reset_u1 got %b want %b", o1, V_RST); end
        checks++; if (o3 !== V_RST) begin fails++; $display("FAIL reset_u3 got %b want %b", o3, V_RST); end
        hazard();
        #1;
        checks++; if (o3 !== V_RST) begin fails++; $display("FAIL reset_hazard_u3 got %b want %b", o3, V_RST); end
        @(negedge clk); idle(); rst_n = 1'b1; #1;
        checks++; if (o1 !== V_PASS) begin fails++; $display("FAIL post_reset_u1 got %b want %b", o1, V_PASS); end
        checks++; if (o3 !== V_PASS) begin fails++; $display("FAIL post_reset_u3 got %b want %b", o3, V_PASS); end
    endtask

    task automatic test_lat1();
        @(negedge clk); hazard(); #1;
        checks++; if (o1 !== V_STALL) begin fails++; $display("FAIL lat1_c0_u1 got %b want %b", o1, V_STALL); end
        checks++; if (o3 !== V_STALL) begin fails++; $display("FAIL lat1_c0_u3 got %b want %b", o3, V_STALL); end
        @(negedge clk); idle(); #1;
        checks++; if (o1 !== V_PASS) begin fails++; $display("FAIL lat1_c1_u1 got %b want %b", o1, V_PASS); end
        checks++; if (o3 !== V_STALL) begin fails++; $display("FAIL lat1_c1_u3 got %b want %b", o3, V_STALL); end
        @(negedge clk); #1;
        checks++; if (o3 !== V_STALL) begin fails++; $display("FAIL lat1_c2_u3 got %b want %b", o3, V_STALL); end
        @(negedge clk); #1;
        checks++; if (o3 !== V_PASS) begin fails++; $display("FAIL lat1_c3_u3 got %b want %b", o3, V_PASS); end
    endtask

    task automatic test_lat3_rt();
`ifdef HAZARD_PERF_CNT_EN
        @(negedge clk); perf_clr = 1'b1;
        @(negedge clk); perf_clr = 1'b0;
`endif
        @(negedge clk); idle(); mr = 1'b1; exrd = 5'd7; rt = 5'd7; uses_rt = 1'b1; rs = 5'd3; #1;
        checks++; if (o3 !== V_STALL) begin fails++; $display("FAIL lat3_c0_u3 got %b want %b", o3, V_STALL); end
        @(negedge clk); idle(); #1;
        checks++; if (o3 !== V_STALL) begin fails++; $display("FAIL lat3_c1_u3 got %b want %b", o3, V_STALL); end
        checks++; if (o1 !== V_PASS) begin fails++; $display("FAIL lat3_c1_u1 got %b want %b", o1, V_PASS); end
        @(negedge clk); #1;
        checks++; if (o3 !== V_STALL) begin fails++; $display("FAIL lat3_c2_u3 got %b want %b", o3, V_STALL); end
        @(negedge clk); #1;
        checks++; if (o3 !== V_PASS) begin fails++; $display("FAIL lat3_c3_u3 got %b want %b", o3, V_PASS); end
`ifdef HAZARD_PERF_CNT_EN
        checks++; if (ps3 !== 16'd3) begin fails++; $display("FAIL perf_stalls_u3 got %0d want 3", ps3); end
        checks++; if (ps1 !== 16'd1) begin fails++; $display("FAIL perf_stalls_u1 got %0d want 1", ps1); end
        @(negedge clk); perf_clr = 1'b1;
        @(negedge clk); perf_clr = 1'b0; #1;
        checks++; if (ps3 !== 16'd0) begin fails++; $display("FAIL perf_clr_u3 got %0d want 0", ps3); end
`endif
    endtask

    task automatic test_no_hazard();
        @(negedge clk); idle(); mr = 1'b1; exrd = 5'd0; rs = 5'd0; #1;
        checks++; if (o1 !== V_PASS) begin fails++; $display("FAIL r0_u1 got %b want %b", o1, V_PASS); end
        checks++; if (o3 !== V_PASS) begin fails++; $display("FAIL r0_u3 got %b want %b", o3, V_PASS); end
        @(negedge clk); idle(); mr = 1'b1; exrd = 5'd6; rt = 5'd6; rs = 5'd1; uses_rt = 1'b0; #1;
        checks++; if (o3 !== V_PASS) begin fails++; $display("FAIL no_rt_use_u3 got %b want %b", o3, V_PASS); end
        @(negedge clk); idle(); mr = 1'b0; exrd = 5'd5; rs = 5'd5; #1;
        checks++; if (o3 !== V_PASS) begin fails++; $display("FAIL no_load_u3 got %b want %b", o3, V_PASS); end
    endtask

    task automatic test_mem_busy();
        @(negedge clk); hazard(); #1;
        checks++; if (o3 !== V_STALL) begin fails++; $display("FAIL busy_c0_u3 got %b want %b", o3, V_STALL); end
        @(negedge clk); idle(); busy = 1'b1; #1;
        checks++; if (o3 !== V_FRZLU) begin fails++; $display("FAIL busy_c1_u3 got %b want %b", o3, V_FRZLU); end
        checks++; if (o1 !== V_FRZ) begin fails++; $display("FAIL busy_c1_u1 got %b want %b", o1, V_FRZ); end
        @(negedge clk); busy = 1'b1; br = 1'b1; #1;
        checks++; if (o3 !== V_FRZLU) begin fails++; $display("FAIL busy_br_u3 got %b want %b", o3, V_FRZLU); end
        @(negedge clk); idle(); #1;
        checks++; if (o3 !== V_STALL) begin fails++; $display("FAIL busy_c3_u3 got %b want %b", o3, V_STALL); end
        checks++; if (o1 !== V_PASS) begin fails++; $display("FAIL busy_c3_u1 got %b want %b", o1, V_PASS); end
        @(negedge clk); #1;
        checks++; if (o3 !== V_STALL) begin fails++; $display("FAIL busy_c4_u3 got %b want %b", o3, V_STALL); end
        @(negedge clk); #1;
        checks++; if (o3 !== V_PASS) begin fails++; $display("FAIL busy_c5_u3 got %b want %b", o3, V_PASS); end
    endtask

    task automatic test_branch();
        @(negedge clk); idle(); br = 1'b1; #1;
        checks++; if (o1 !== V_FLUSH) begin fails++; $display("FAIL br_u1 got %b want %b", o1, V_FLUSH); end
        checks++; if (o3 !== V_FLUSH) begin fails++; $display("FAIL br_u3 got %b want %b", o3, V_FLUSH); end
        @(negedge clk); br = 1'b1; busy = 1'b1; #1;
        checks++; if (o1 !== V_FRZ) begin fails++; $display("FAIL br_busy_u1 got %b want %b", o1, V_FRZ); end
        @(negedge clk); hazard(); #1;
        checks++; if (o3 !== V_STALL) begin fails++; $display("FAIL br_abort_c0_u3 got %b want %b", o3, V_STALL); end
        @(negedge clk); idle(); br = 1'b1; #1;
        checks++; if (o3 !== V_FLUSH) begin fails++; $display("FAIL br_abort_c1_u3 got %b want %b", o3, V_FLUSH); end
        @(negedge clk); idle(); #1;
        checks++; if (o3 !== V_PASS) begin fails++; $display("FAIL br_abort_c2_u3 got %b want %b", o3, V_PASS); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk); hazard(); #1;
        checks++; if (o3 !== V_STALL) begin fails++; $display("FAIL b2b_c0_u3 got %b want %b", o3, V_STALL); end
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk); idle(); #1;
            checks++; if (o3 !== V_STALL) begin fails++; $display("FAIL b2b_c%0d_u3 got %b want %b", i, o3, V_STALL); end
        end
        @(negedge clk); hazard(); #1;
        checks++; if (o3 !== V_STALL) begin fails++; $display("FAIL b2b_c3_u3 got %b want %b", o3, V_STALL); end
        for (int i = 4; i <= 5; i++) begin
            @(negedge clk); idle(); #1;
            checks++; if (o3 !== V_STALL) begin fails++; $display("FAIL b2b_c%0d_u3 got %b want %b", i, o3, V_STALL); end
        end
        @(negedge clk); #1;
        checks++; if (o3 !== V_PASS) begin fails++; $display("FAIL b2b_c6_u3 got %b want %b", o3, V_PASS); end
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk); hazard();
        @(negedge clk); idle(); #1;
        checks++; if (o3 !== V_STALL) begin fails++; $display("FAIL rstmid_pre_u3 got %b want %b", o3, V_STALL); end
        #1 rst_n = 1'b0; #1;
        checks++; if (o3 !== V_RST) begin fails++; $display("FAIL rstmid_u3 got %b want %b", o3, V_RST); end
`ifdef HAZARD_PERF_CNT_EN
        checks++; if (ps3 !== 16'd0) begin fails++; $display("FAIL rstmid_perf_u3 got %0d want 0", ps3); end
`endif
        @(negedge clk); rst_n = 1'b1; #1;
        checks++; if (o3 !== V_PASS) begin fails++; $display("FAIL rstmid_after_u3 got %b want %b", o3, V_PASS); end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf();
        @(negedge clk); idle(); perf_clr = 1'b1;
        @(negedge clk); perf_clr = 1'b0; br = 1'b1;
        @(negedge clk); br = 1'b1; busy = 1'b1;
        @(negedge clk); idle(); #1;
        checks++; if (pf1 !== 16'd1) begin fails++; $display("FAIL perf_flush_u1 got %0d want 1", pf1); end
        @(negedge clk); perf_clr = 1'b1; br = 1'b1;
        @(negedge clk); perf_clr = 1'b0; idle(); #1;
        checks++; if (pf1 !== 16'd0) begin fails++; $display("FAIL perf_clr_wins_u1 got %0d want 0", pf1); end
        @(negedge clk); hazard();
        repeat (65534) @(negedge clk);
        #1;
        checks++; if (ps1 !== 16'hFFFE) begin fails++; $display("FAIL perf_near_sat_u1 got %h want fffe", ps1); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (ps1 !== 16'hFFFF) begin fails++; $display("FAIL perf_sat_u1 got %h want ffff", ps1); end
        @(negedge clk); idle();
    endtask
`endif

    initial begin
        #1_500_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef HAZARD_PERF_CNT_EN
        perf_clr = 1'b0;
`endif
        test_reset();
        test_lat1();
        test_lat3_rt();
        test_no_hazard();
        test_mem_busy();
        test_branch();
        test_back_to_back();
        test_reset_mid_stall();
`ifdef HAZARD_PERF_CNT_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
